// File: rtl/fixed_div_refine.sv
// Refinement stage for the coarse fixed-point divider: corrects a quotient seed to the
// exact truncated quotient using a residual and a radix-2 restoring division.
module fixed_div_refine #(
  parameter int unsigned N    = 32,
  parameter int unsigned FRAC = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] q_seed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         div_by_zero,
  output logic         sat
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned MW = W2 + 1;
  localparam int unsigned CW = $clog2(W2);

  typedef enum logic [2:0] {IDLE, RESID, DIV, CORR, DONE} state_t;

  state_t          state_q;
  logic            sign_q, neg_q;
  logic [N-1:0]    ma_q, mb_q, ms_q;
  logic [W2-1:0]   m_q, c_q;
  logic [N:0]      rem_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    q_q;
  logic            dbz_q, sat_q, out_valid_q, in_ready_q;

  function automatic logic [N-1:0] mag_of(input logic [N-1:0] x);
    return x[N-1] ? (~x + 1'b1) : x;
  endfunction

  logic [W2-1:0]   prod;
  logic [W2:0]     e;
  logic [W2-1:0]   m_d;
  logic [N:0]      trial, rem_d;
  logic            qbit_d;
  logic [MW-1:0]   mag, limit, mag_c;
  logic            sat_d;
  logic [N-1:0]    q_d;

  always_comb begin
    prod  = W2'(ms_q) * W2'(mb_q);
    e     = (MW'(ma_q) << FRAC) - MW'(prod);
    m_d   = e[W2] ? W2'(-e) : e[W2-1:0];

    trial  = {rem_q[N-1:0], m_q[W2-1]};
    qbit_d = (trial >= {1'b0, mb_q});
    rem_d  = qbit_d ? (trial - {1'b0, mb_q}) : trial;

    // A negative residual means the seed overshot; a nonzero remainder costs one more unit.
    if (neg_q) mag = MW'(ms_q) - MW'(c_q) - MW'(rem_q != '0);
    else       mag = MW'(ms_q) + MW'(c_q);
    limit = sign_q ? (MW'(1) << (N - 1)) : ((MW'(1) << (N - 1)) - MW'(1));
    sat_d = (mag > limit);
    mag_c = sat_d ? limit : mag;
    q_d   = sign_q ? (~mag_c[N-1:0] + 1'b1) : mag_c[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      neg_q       <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      ms_q        <= '0;
      m_q         <= '0;
      c_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      dbz_q       <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          sign_q     <= a[N-1] ^ b[N-1];
          ma_q       <= mag_of(a);
          mb_q       <= mag_of(b);
          ms_q       <= mag_of(q_seed);
          in_ready_q <= 1'b0;
          sat_q      <= 1'b0;
          if (b == '0) begin
            dbz_q   <= 1'b1;
            q_q     <= a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            state_q <= DONE;
          end else begin
            dbz_q   <= 1'b0;
            state_q <= RESID;
          end
        end
        RESID: begin
          neg_q   <= e[W2];
          m_q     <= m_d;
          rem_q   <= '0;
          c_q     <= '0;
          cnt_q   <= '0;
          state_q <= DIV;
        end
        DIV: begin
          rem_q <= rem_d;
          c_q   <= {c_q[W2-2:0], qbit_d};
          m_q   <= {m_q[W2-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W2 - 1)) state_q <= CORR;
        end
        CORR: begin
          q_q         <= q_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // The divide-by-zero path enters here with out_valid still low; raise it one cycle later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign q           = q_q;
  assign div_by_zero = dbz_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_fixed_div_refine.sv
// Directed self-checking bench for fixed_div_refine with hand-computed quotients.
module tb_fixed_div_refine;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, dbz, sat;
  logic [31:0] a, b, q_seed, q;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fixed_div_refine #(.N(32), .FRAC(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .q_seed(q_seed),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div_by_zero(dbz), .sat(sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] ts, input logic [31:0] eq,
                        input logic edbz, input logic esat, input int elat);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    check({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb_v; q_seed = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; q_seed = 32'h12345678;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_q"}, q, eq);
    check({tag, "_dbz"}, dbz, edbz);
    check({tag, "_sat"}, sat, esat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 0);
  endtask

  initial begin
    int w;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; q_seed = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_dbz", dbz, 0);
    check("rst_sat", sat, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_op("exact3",     32'h00003000, 32'h00001000, 32'h00003000, 32'h00003000, 0, 0, 66);
    run_op("seed_high",  32'h00001000, 32'h00003000, 32'h00000571, 32'h00000555, 0, 0, 66);
    run_op("neg_a",      32'hFFFFF000, 32'h00002000, 32'h00000800, 32'hFFFFF800, 0, 0, 66);
    run_op("neg_b",      32'h00005000, 32'hFFFFE000, 32'h00000000, 32'hFFFFD800, 0, 0, 66);
    run_op("dbz_pos",    32'h00001234, 32'h00000000, 32'h00000077, 32'h7FFFFFFF, 1, 0, 1);
    run_op("dbz_neg",    32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h80000000, 1, 0, 1);
    run_op("sat_pos",    32'h7FFFFFFF, 32'h00000001, 32'h00003000, 32'h7FFFFFFF, 0, 1, 66);
    run_op("sat_neg",    32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000, 0, 1, 66);
    run_op("neg_limit",  32'h80000000, 32'h00001000, 32'h00000000, 32'h80000000, 0, 0, 66);
    run_op("pos_limit",  32'h7FFFFFFF, 32'h00001000, 32'hFFFFFFFF, 32'h7FFFFFFF, 0, 0, 66);
    run_op("neg_zero",   32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h00000000, 0, 0, 66);

    // Result held while the consumer stalls; new operands must not be accepted.
    a = 32'h00003000; b = 32'h00001000; q_seed = 32'h00003000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
    check("hold_latency", w, 66);
    a = 32'h00001000; b = 32'h00000000; q_seed = 32'h0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_q", q, 32'h00003000);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_dbz", dbz, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release", out_valid, 0);
    check("hold_idle", in_ready, 1);

    // Reset during division discards the operation.
    a = 32'h00001000; b = 32'h00003000; q_seed = 32'h00000571; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_q", q, 0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    run_op("after_rst",  32'h00001000, 32'h00003000, 32'h00000571, 32'h00000555, 0, 0, 66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_div_refine.md
# fixed_div_refine

Multi-cycle refinement stage that sits directly downstream of the combinational coarse fixed-point divider. It accepts the dividend `a`, the divisor `b` and the coarse quotient estimate `q_seed`. It computes the residual `|a|·2^FRAC − |q_seed|·|b|` and runs a radix-2 restoring division of that residual by `|b|`. It then corrects the seed to the exact truncated quotient and returns the signed result through a valid/ready handshake.

## Interface
- `N`, 32, operand/result width, two's complement
- `FRAC`, 12, fractional bits (1.0 = `1 << FRAC` = 0x1000)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  stage can accept operands
- `a`  in  N  dividend
- `b`  in  N  divisor
- `q_seed`  in  N  coarse quotient from the upstream divider; only its magnitude is used
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `q`  out  N  quotient, two's complement
- `div_by_zero`  out  1  result produced with `b == 0`
- `sat`  out  1  result magnitude was clamped

## Operation
- **States:**
  - IDLE → RESID → DIV → CORR → DONE → IDLE.
  - IDLE also goes directly to DONE when `b == 0`.
- **IDLE:**
  - `in_ready = 1`.
  - On `in_valid && in_ready`, register the following and go to RESID:
    - `sign = a[N-1] ^ b[N-1]`
    - `ma = |a|`, `mb = |b|`, `ms = |q_seed|`, each N-bit unsigned, so |0x80000000| = 2^(N-1).
  - If `b == 0`:
    - Go to DONE with `div_by_zero = 1`.
    - Set `q = 0x7FFFFFFF` if `a[N-1] == 0`, else `0x80000000`.
- **RESID:**
  - `e = (ma << FRAC) − ms·mb`, signed, 2N+1 bits.
  - Store `neg = e < 0` and `m = |e|` (2N bits).
  - Clear the remainder and the iteration counter.
- **DIV:** 2N iterations of restoring division of `m` by `mb`, MSB first.
  - Remainder is N+1 bits; correction quotient `c` is 2N bits.
  - One quotient bit per cycle.
  - Counter reaches 2N−1 → CORR.
- **CORR:**
  - `neg == 0`: `mag = ms + c`.
  - `neg == 1`: `mag = ms − c − (rem != 0)`.
  - Result equals `floor(|a|·2^FRAC / |b|)`, i.e. truncation toward zero.
  - `mag` is computed wide enough that neither addition overflows nor subtraction underflows.
  - Clamp:
    - Positive limit 2^(N-1)−1, negative limit 2^(N-1); set `sat = 1` when clamping.
    - `q = sign ? −mag : mag`.
    - `mag == 0` gives `q = 0` regardless of sign.
- **DONE:**
  - `out_valid = 1`; `q`, `div_by_zero` and `sat` are held stable.
  - On `out_ready` go to IDLE and drop `out_valid`.
- `in_ready = 1` only in IDLE; there is never more than one operation in flight.
- A seed of any value, however inaccurate, must still yield the exact result.

## Timing
- Accept edge k; RESID is evaluated at edge k+1; DIV covers edges k+2 … k+2N+1; CORR registers the result at edge k+2N+2.
- `out_valid` is high after edge k+2N+2 (66 cycles for N=32).
- Divide-by-zero: `out_valid` is high after edge k+1.
- Result transfers on the edge where `out_valid && out_ready`.
  - Next accept is possible no earlier than the following edge, since `in_ready` rises after the return to IDLE.
- **Reset:**
  - `rst` high at an edge → state IDLE, `out_valid = 0`, `q = 0`, `div_by_zero = 0`, `sat = 0`, counter 0.
  - `in_ready = 1` from the next cycle.
  - Reset mid-operation discards the operation; no `out_valid` pulse follows.
- `rst` has priority over every handshake in the same cycle.
- Inputs are ignored outside IDLE. `a`, `b` and `q_seed` need not be held after the accept edge.

## Test plan
- a=0x3000, b=0x1000, q_seed=0x3000 → q=0x3000, sat=0, div_by_zero=0; `out_valid` exactly 66 cycles after accept.
- a=0x1000, b=0x3000, q_seed=0x0571 (seed too high, negative residual) → q=0x0555.
- a=0xFFFFF000, b=0x2000, q_seed=0x0800 → q=0xFFFFF800; a=0x00005000, b=0xFFFFE000, q_seed=0 → q=0xFFFFD800.
- b=0 with a=0x1234 → q=0x7FFFFFFF, div_by_zero=1, one cycle after accept; with a=0xFFFF0000 → q=0x80000000.
- Saturation, a=0x7FFFFFFF, b=0x00000001, q_seed=0x00003000 → q=0x7FFFFFFF, sat=1.
- Handshake and reset:
  - Hold `out_ready = 0` for 10 cycles with the result pending → `q` stable, `in_ready = 0`, no new accept.
  - Assert `rst` at cycle 30 of an operation → no `out_valid`; the next operation returns the correct result.
